// File: rtl/mod_beep_meter.sv
// mod_beep_meter
//   Watches a square-wave pin and measures the length of a beep tone. Every
//   transition (rising or falling) of the synchronized pin ends a
//   half-period interval. Intervals inside the accepted window are counted.
//   When the tone stops, or a too-short interval (glitch) appears, the
//   measurement is reported as a number of full cycles with a one-clock
//   valid pulse.
//
// Parameters
//   simulation : 1 shortens the nominal half-period to 11 clocks (else 2001)
//   tol        : accepted deviation of a half-period from nominal, in clocks
//
// Ports
//   clk_4M_i    : 4 MHz clock
//   rst_i       : asynchronous active-high reset
//   pin_i       : monitored pin, asynchronous to clk_4M_i
//   en_i        : measurement enable; dropping it aborts a measurement
//   cyc_o       : high while a measurement is in progress
//   valid_o     : one-clock pulse when period_ms_o / err_o are updated
//   period_ms_o : measured tone length in full cycles
//   err_o       : the reported measurement is malformed
module mod_beep_meter #(
  parameter int simulation = 0,
  parameter int tol        = 200
) (
  input  logic        clk_4M_i,
  input  logic        rst_i,
  input  logic        pin_i,
  input  logic        en_i,
  output logic        cyc_o,
  output logic        valid_o,
  output logic [31:0] period_ms_o,
  output logic        err_o
);

  localparam int HALF_NOM = (simulation != 0) ? 11 : 2001;
  localparam int HALF_MIN = HALF_NOM - tol;
  localparam int HALF_MAX = HALF_NOM + tol;

  // Interval is hcnt+1, so it needs one bit more than hcnt.
  localparam logic [12:0] IV_MIN = 13'(HALF_MIN);
  localparam logic [12:0] IV_MAX = 13'(HALF_MAX);
  localparam logic [11:0] HC_MAX = 12'(HALF_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    DONE = 2'd2
  } state_e;

  // sync_q[0]: metastability flop, sync_q[1]: pin_s, sync_q[2]: pin_s delayed
  logic [2:0]  sync_q;
  logic        edge_s;

  state_e      state_q;
  logic [11:0] hcnt_q;
  logic [11:0] hcnt_d;
  logic [32:0] halves_q;
  logic [32:0] halves_d;
  logic        errf_q;
  logic [31:0] period_d;

  logic [12:0] interval;
  logic [33:0] rounded;

  assign edge_s   = sync_q[1] ^ sync_q[2];
  assign interval = {1'b0, hcnt_q} + 13'd1;

  // Both counters saturate instead of wrapping.
  assign hcnt_d   = (&hcnt_q)   ? hcnt_q   : hcnt_q + 12'd1;
  assign halves_d = (&halves_q) ? halves_q : halves_q + 33'd1;

  // 2N edges give 2N-1 intervals; rounding up the halving reports N.
  // The result can reach 2^32 only when halves is saturated; clamp it.
  assign rounded  = ({1'b0, halves_q} + 34'd1) >> 1;
  assign period_d = (rounded[33:32] != 2'b00) ? 32'hFFFF_FFFF : rounded[31:0];

  always_ff @(posedge clk_4M_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], pin_i};
    end
  end

  always_ff @(posedge clk_4M_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      hcnt_q      <= '0;
      halves_q    <= '0;
      errf_q      <= 1'b0;
      cyc_o       <= 1'b0;
      valid_o     <= 1'b0;
      period_ms_o <= '0;
      err_o       <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          cyc_o <= 1'b0;
          if (edge_s && en_i) begin
            state_q  <= MEAS;
            hcnt_q   <= '0;
            halves_q <= '0;
            cyc_o    <= 1'b1;
          end
        end

        MEAS: begin
          if (!en_i) begin
            // Aborted: nothing is reported, outputs keep the last result.
            state_q <= IDLE;
            cyc_o   <= 1'b0;
          end else if (edge_s) begin
            if (interval < IV_MIN) begin
              errf_q  <= 1'b1;
              state_q <= DONE;
            end else if (interval <= IV_MAX) begin
              halves_q <= halves_d;
              hcnt_q   <= '0;
            end else begin
              // Edge landing on the timeout clock: the interval is one too
              // long, so it closes the tone like a plain timeout.
              errf_q  <= (halves_q == '0);
              state_q <= DONE;
            end
          end else if (hcnt_q == HC_MAX) begin
            // Tone ended; a lone starting edge is not a tone.
            errf_q  <= (halves_q == '0);
            state_q <= DONE;
          end else begin
            hcnt_q <= hcnt_d;
          end
        end

        DONE: begin
          period_ms_o <= period_d;
          err_o       <= errf_q;
          valid_o     <= 1'b1;
          cyc_o       <= 1'b0;
          state_q     <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          cyc_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mod_beep_meter.md
Name: mod_beep_meter

Overview:
- Receive-side counterpart of the buzzer driver: monitors a square-wave pin and detects a beep tone (~1 kHz toggling from a 4 MHz clock).
- Measures the tone's duration in full cycles (≈ms) and reports it with a one-cycle valid pulse.
- Used for loopback self-test of the buzzer path and for sensing an external beeper.

Parameters:
- simulation, 0, 1 selects shortened timing: nominal half-period 11 clocks instead of 2001.
- tol, 200, accepted deviation of a half-period from nominal, in clocks. Benches set it to 3 when simulation=1.
- Derived: half_nom = simulation ? 11 : 2001; half_min = half_nom - tol; half_max = half_nom + tol.

Ports:
- clk_4M_i  input  1  4 MHz clock.
- rst_i  input  1  reset, asynchronous, active-high.
- pin_i  input  1  monitored pin, asynchronous to clk_4M_i.
- en_i  input  1  measurement enable.
- cyc_o  output  1  high while a tone measurement is in progress.
- valid_o  output  1  one-clock pulse when period_ms_o and err_o are updated.
- period_ms_o  output  32  measured tone length in full cycles.
- err_o  output  1  qualifies valid_o: the measurement is malformed.

Behaviour:
- Reset values: cyc_o=0, valid_o=0, period_ms_o=0, err_o=0, state IDLE, synchronizer flops=0, all counters=0.
- Input conditioning:
  - Two-flop synchronizer on pin_i produces pin_s.
  - Edge = pin_s differs from its one-clock-delayed copy.
  - Any edge type counts (rising or falling).
- Counters:
  - hcnt: 12 bits, saturating; counts clocks since the last edge.
  - halves: 33 bits, saturating; counts valid intervals.
- State IDLE:
  - cyc_o=0.
  - Edge with en_i=1 → MEAS, with hcnt<=0, halves<=0, cyc_o<=1.
  - Edges while en_i=0 are ignored.
- State MEAS, evaluated each clock in this priority order:
  1. en_i=0 → IDLE, cyc_o<=0. No valid_o pulse; the measurement is discarded.
  2. Edge:
     - Interval = hcnt+1.
     - half_min ≤ interval ≤ half_max → halves<=halves+1, hcnt<=0, stay in MEAS.
     - interval < half_min (glitch) → DONE with err flag set.
  3. No edge and hcnt == half_max (tone ended) → DONE with err flag = (halves==0).
  4. Otherwise hcnt<=hcnt+1.
- State DONE, one clock:
  - period_ms_o <= (halves+1)>>1, truncated to 32 bits; saturates at 2^32-1.
  - err_o <= err flag; valid_o <= 1; cyc_o <= 0.
  - Next state IDLE.
- Outputs between measurements:
  - valid_o is high for exactly one clock per completed measurement.
  - period_ms_o and err_o hold until the next DONE.
- Semantics: 2N edges give 2N-1 intervals, which report N. This matches a buzzer programmed with period N.
- Latency: valid_o rises half_max+2 clocks after the clock in which the last edge is detected on pin_s. pin_s itself lags pin_i by 2 clocks.
- An edge arriving in the same clock as the timeout condition counts as an edge: priority 2 beats priority 3.
- An edge arriving in DONE is ignored; an edge in the following IDLE clock starts a new measurement.
- rst_i asserted mid-measurement: immediate return to reset values, no valid_o.
- After reset the synchronizer holds 0, so a pin already high produces one edge. With no further toggles this yields valid_o with period_ms_o=0 and err_o=1. This is the accepted behaviour.

Test Plan (simulation=1, tol=3, so the accepted window is [8,14]):
- 20 toggles of pin_i every 11 clocks, en_i=1 → cyc_o high during the tone; one valid_o pulse with period_ms_o=10, err_o=0, 16 clocks after the last synchronized edge.
- 21 toggles spaced 9, 13, 9, 13, … clocks → period_ms_o=10 (20 intervals), err_o=0. Repeat with spacing 14 → accepted; spacing 15 → tone ends after the first edge, period_ms_o=0, err_o=1.
- 6 toggles at 11 clocks, then a 3-clock glitch pulse → valid_o with period_ms_o=3 ((5+1)>>1), err_o=1.
- Tone in progress, then en_i dropped after 8 toggles → cyc_o falls next clock, no valid_o, period_ms_o keeps its previous value; a later 4-toggle tone reports period_ms_o=2.
- rst_i pulsed mid-tone → all outputs 0 asynchronously, no valid_o; toggling resumed after release starts a fresh measurement.
- Single edge then silence → valid_o with period_ms_o=0, err_o=1; back-to-back tones separated by 20 idle clocks → two separate valid_o pulses with correct counts.
